// File: rtl/branch_pkg.sv
// Shared definitions for the branch sequencer: condition codes, FSM encoding
// and the {Z,V,N} flag bundle.
package branch_pkg;

    typedef enum logic [2:0] {
        COND_NEQ   = 3'd0,
        COND_EQ    = 3'd1,
        COND_GT    = 3'd2,
        COND_LT    = 3'd3,
        COND_GTE   = 3'd4,
        COND_LTE   = 3'd5,
        COND_OVFL  = 3'd6,
        COND_UNCON = 3'd7
    } cond_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator.
module branch_cond
    import branch_pkg::*;
(
    input  cond_e  iOp,
    input  flags_t iFlags,
    output logic   oTaken
);

    always_comb begin
        oTaken = 1'b0;
        case (iOp)
            COND_NEQ:   oTaken = ~iFlags.z;
            COND_EQ:    oTaken = iFlags.z;
            COND_GT:    oTaken = ~iFlags.z & ~iFlags.n;
            COND_LT:    oTaken = iFlags.n;
            COND_GTE:   oTaken = ~iFlags.n;
            COND_LTE:   oTaken = iFlags.n | iFlags.z;
            COND_OVFL:  oTaken = iFlags.v;
            COND_UNCON: oTaken = 1'b1;
            default:    oTaken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch PC sequencer with conditional branch redirect and pipeline flush.
// Optional taken-branch statistics counter enabled by the BRANCH_STATS_EN macro.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            iClk,
    input  logic            iRst_n,
    input  logic            iStall,
    input  logic            iFlagsWe,
    input  logic            iZeroFlag,
    input  logic            iOverflowFlag,
    input  logic            iNegativeFlag,
    input  logic            iBranchValid,
    input  logic [2:0]      iBranchOp,
    input  logic [PC_W-1:0] iBranchTarget,
    output logic [PC_W-1:0] oPc,
    output logic            oBranchTaken,
    output logic            oFlush,
    output logic            oBusy
`ifdef BRANCH_STATS_EN
    ,
    input  logic            iStatsClr,
    output logic [15:0]     oTakenCount
`endif
);

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    logic [PC_W-1:0] pc_q, pc_d;
    flags_t          flags_q, flags_d, flags_in, flags_eff;
    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            taken_q, taken_d;
    logic            cond_true;

    assign flags_in  = '{z: iZeroFlag, v: iOverflowFlag, n: iNegativeFlag};
    // Same-cycle flag writes are forwarded so a compare+branch pair needs no bubble.
    assign flags_eff = iFlagsWe ? flags_in : flags_q;

    branch_cond u_cond (
        .iOp    (cond_e'(iBranchOp)),
        .iFlags (flags_eff),
        .oTaken (cond_true)
    );

    always_comb begin
        pc_d    = pc_q;
        flags_d = flags_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        taken_d = taken_q;
        if (!iStall) begin
            taken_d = 1'b0;
            pc_d    = pc_q + 1'b1;
            if (iFlagsWe) flags_d = flags_in;
            case (state_q)
                ST_RUN: begin
                    if (iBranchValid && cond_true) begin
                        pc_d    = iBranchTarget;
                        taken_d = 1'b1;
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LAST;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == 3'd0) state_d = ST_RUN;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pc_q    <= '0;
            flags_q <= '0;
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            taken_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flags_q <= flags_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            taken_q <= taken_d;
        end
    end

    // A redirect pulse caught by a stall is held and shown once the stall lifts.
    assign oPc          = pc_q;
    assign oBranchTaken = taken_q & ~iStall;
    assign oFlush       = (state_q == ST_FLUSH);
    assign oBusy        = (state_q == ST_FLUSH);

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_q;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)                                    taken_cnt_q <= 16'h0000;
        else if (iStatsClr)                             taken_cnt_q <= 16'h0000;
        else if (oBranchTaken && taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'h0001;
    end

    assign oTakenCount = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed vector table, hand-written corner
// sequences, then randomized traffic against a reference model.
module tb_branch_sequencer;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, we, zf, vf, nf, valid, clr;
    logic [2:0]  op;
    logic [15:0] tgt;

    logic [15:0] pc;
    logic        taken, flush, busy;
    logic [7:0]  pc8;
    logic        taken8, flush8, busy8;
    logic [15:0] cnt, cnt8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_sequencer #(.PC_W(16), .FLUSH_CYCLES(FC)) u_dut (
        .iClk(clk), .iRst_n(rst_n), .iStall(stall), .iFlagsWe(we),
        .iZeroFlag(zf), .iOverflowFlag(vf), .iNegativeFlag(nf),
        .iBranchValid(valid), .iBranchOp(op), .iBranchTarget(tgt),
        .oPc(pc), .oBranchTaken(taken), .oFlush(flush), .oBusy(busy)
`ifdef BRANCH_STATS_EN
        , .iStatsClr(clr), .oTakenCount(cnt)
`endif
    );

    branch_sequencer #(.PC_W(8), .FLUSH_CYCLES(FC)) u_dut8 (
        .iClk(clk), .iRst_n(rst_n), .iStall(stall), .iFlagsWe(we),
        .iZeroFlag(zf), .iOverflowFlag(vf), .iNegativeFlag(nf),
        .iBranchValid(valid), .iBranchOp(op), .iBranchTarget(tgt[7:0]),
        .oPc(pc8), .oBranchTaken(taken8), .oFlush(flush8), .oBusy(busy8)
`ifdef BRANCH_STATS_EN
        , .iStatsClr(clr), .oTakenCount(cnt8)
`endif
    );

    // Reference model: pc, architectural flags, flush cycles still owed,
    // a pending redirect pulse and the taken-branch tally.
    int m_pc, m_flush_left, m_cnt;
    bit m_z, m_v, m_n, m_pulse;

    function automatic bit cond_holds(input logic [2:0] c, input bit z, input bit v, input bit n);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0; m_flush_left = 0; m_cnt = 0;
        m_z = 0; m_v = 0; m_n = 0; m_pulse = 0;
    endtask

    task automatic model_step();
        bit fz, fv, fn, acc;
        fz = we ? zf : m_z;
        fv = we ? vf : m_v;
        fn = we ? nf : m_n;
        if (clr) m_cnt = 0;
        else if (m_pulse && !stall && m_cnt < 65535) m_cnt++;
        if (!stall) begin
            acc = (m_flush_left == 0) && valid && cond_holds(op, fz, fv, fn);
            if (we) begin m_z = zf; m_v = vf; m_n = nf; end
            if (m_flush_left > 0) m_flush_left--;
            if (acc) begin
                m_pc = int'(tgt); m_flush_left = FC; m_pulse = 1;
            end else begin
                m_pc = (m_pc + 1) % 65536; m_pulse = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        stall = 0; we = 0; zf = 0; vf = 0; nf = 0; valid = 0; op = 3'd0; tgt = 16'h0; clr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_model(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'(m_pc));
        check({tag, "_pc8"}, 32'(pc8), 32'(m_pc % 256));
        check({tag, "_taken"}, 32'(taken), 32'(m_pulse && !stall));
        check({tag, "_flush"}, 32'(flush), 32'(m_flush_left > 0));
        check({tag, "_busy"}, 32'(busy), 32'(m_flush_left > 0));
`ifdef BRANCH_STATS_EN
        check({tag, "_cnt"}, 32'(cnt), 32'(m_cnt));
`endif
    endtask

    typedef struct {
        bit          stall, we, z, valid;
        bit [2:0]    op;
        bit [15:0]   tgt;
        bit [15:0]   e_pc;
        bit          e_t, e_f;
    } vec_t;

    function automatic vec_t mk(bit s, bit w, bit z, bit vl, bit [2:0] o, bit [15:0] t,
                                bit [15:0] p, bit et, bit ef);
        vec_t r;
        r.stall = s; r.we = w; r.z = z; r.valid = vl; r.op = o; r.tgt = t;
        r.e_pc = p; r.e_t = et; r.e_f = ef;
        return r;
    endfunction

    vec_t vecs[26];

    initial begin
        vecs[0]  = mk(0,0,0,0,0,16'h0000, 16'h0000,0,0);
        vecs[1]  = mk(0,0,0,0,0,16'h0000, 16'h0001,0,0);
        vecs[2]  = mk(0,0,0,0,0,16'h0000, 16'h0002,0,0);
        vecs[3]  = mk(0,0,0,0,0,16'h0000, 16'h0003,0,0);
        vecs[4]  = mk(0,0,0,0,0,16'h0000, 16'h0004,0,0);
        vecs[5]  = mk(0,1,1,1,1,16'h0040, 16'h0005,0,0);
        vecs[6]  = mk(0,0,0,0,0,16'h0000, 16'h0040,1,1);
        vecs[7]  = mk(0,0,0,0,0,16'h0000, 16'h0041,0,1);
        vecs[8]  = mk(0,1,0,0,0,16'h0000, 16'h0042,0,0);
        vecs[9]  = mk(0,0,0,1,1,16'h0000, 16'h0043,0,0);
        vecs[10] = mk(0,0,0,0,0,16'h0000, 16'h0044,0,0);
        vecs[11] = mk(0,0,0,1,7,16'h0080, 16'h0045,0,0);
        vecs[12] = mk(0,0,0,1,7,16'h0100, 16'h0080,1,1);
        vecs[13] = mk(0,0,0,1,7,16'h0100, 16'h0081,0,1);
        vecs[14] = mk(0,0,0,0,0,16'h0000, 16'h0082,0,0);
        vecs[15] = mk(0,0,0,1,7,16'h0200, 16'h0083,0,0);
        vecs[16] = mk(1,0,0,0,0,16'h0000, 16'h0200,0,1);
        vecs[17] = mk(1,0,0,0,0,16'h0000, 16'h0200,0,1);
        vecs[18] = mk(1,0,0,0,0,16'h0000, 16'h0200,0,1);
        vecs[19] = mk(0,0,0,0,0,16'h0000, 16'h0200,1,1);
        vecs[20] = mk(0,0,0,0,0,16'h0000, 16'h0201,0,1);
        vecs[21] = mk(0,0,0,0,0,16'h0000, 16'h0202,0,0);
        vecs[22] = mk(0,0,0,1,7,16'h0204, 16'h0203,0,0);
        vecs[23] = mk(0,0,0,0,0,16'h0000, 16'h0204,1,1);
        vecs[24] = mk(0,0,0,0,0,16'h0000, 16'h0205,0,1);
        vecs[25] = mk(0,0,0,0,0,16'h0000, 16'h0206,0,0);

        do_reset();

        // Directed table: sequential fetch, forwarded EQ, not-taken, shadow branch,
        // stall mid-flush, UNCON to pc+1.
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            set_idle();
            stall = vecs[i].stall; we = vecs[i].we; zf = vecs[i].z;
            valid = vecs[i].valid; op = vecs[i].op; tgt = vecs[i].tgt;
            #1;
            check($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
            check($sformatf("vec%0d_taken", i), 32'(taken), 32'(vecs[i].e_t));
            check($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].e_f));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_f));
            model_step();
        end
`ifdef BRANCH_STATS_EN
        @(negedge clk); set_idle(); #1;
        check("stats_after_table", 32'(cnt), 32'd4);
        model_step();
`endif

        // 8-bit PC wraps 0xFF -> 0x00 while the 16-bit instance continues to 0x100.
        @(negedge clk); set_idle(); valid = 1; op = 3'd7; tgt = 16'h00FF; #1;
        model_step();
        @(negedge clk); set_idle(); #1;
        check("wrap_pc8_ff", 32'(pc8), 32'h0000_00FF);
        check("wrap_pc16_ff", 32'(pc), 32'h0000_00FF);
        model_step();
        @(negedge clk); #1;
        check("wrap_pc8_00", 32'(pc8), 32'h0000_0000);
        check("wrap_pc16_100", 32'(pc), 32'h0000_0100);
        model_step();
        @(negedge clk); #1;
        check("wrap_pc8_01", 32'(pc8), 32'h0000_0001);
        check("wrap_flush_done", 32'(flush), 32'h0);
        model_step();

        // Asynchronous reset while in FLUSH.
        @(negedge clk); set_idle(); valid = 1; op = 3'd7; tgt = 16'h1234; #1;
        model_step();
        @(negedge clk); set_idle(); #1;
        check("rstflush_in_flush", 32'(flush), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rstflush_pc", 32'(pc), 32'h0);
        check("rstflush_taken", 32'(taken), 32'h0);
        check("rstflush_flush", 32'(flush), 32'h0);
        check("rstflush_busy", 32'(busy), 32'h0);
        check("rstflush_pc8", 32'(pc8), 32'h0);
        do_reset();
        @(negedge clk); #1;
        check("post_reset_pc", 32'(pc), 32'h0);
        model_step();
        @(negedge clk); #1;
        check("first_inc_pc", 32'(pc), 32'h1);
        model_step();

`ifdef BRANCH_STATS_EN
        // Three branches, then clear-vs-increment priority, then saturation.
        for (int b = 0; b < 3; b++) begin
            @(negedge clk); set_idle(); valid = 1; op = 3'd7; tgt = 16'(b * 16); #1;
            model_step();
            for (int k = 0; k < FC + 1; k++) begin
                @(negedge clk); set_idle(); #1; check_model("stats3"); model_step();
            end
        end
        check("stats_three", 32'(cnt), 32'd3);
        @(negedge clk); set_idle(); valid = 1; op = 3'd7; tgt = 16'h0010; #1;
        model_step();
        @(negedge clk); set_idle(); clr = 1; #1;
        check_model("stats_clr_pulse");
        model_step();
        @(negedge clk); set_idle(); #1;
        check("stats_clr_priority", 32'(cnt), 32'd0);
        model_step();
        @(negedge clk); set_idle(); #1;
        model_step();
        force u_dut.taken_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release u_dut.taken_cnt_q;
        m_cnt = 65535;
        @(negedge clk); set_idle(); valid = 1; op = 3'd7; tgt = 16'h0020; #1;
        model_step();
        for (int k = 0; k < FC + 1; k++) begin
            @(negedge clk); set_idle(); #1; check_model("stats_sat"); model_step();
        end
        check("stats_saturate", 32'(cnt), 32'hFFFF);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            stall = ($urandom_range(0, 3) == 0);
            we    = ($urandom_range(0, 2) == 0);
            zf    = 1'($urandom_range(0, 1));
            vf    = 1'($urandom_range(0, 1));
            nf    = 1'($urandom_range(0, 1));
            valid = 1'($urandom_range(0, 1));
            op    = 3'($urandom_range(0, 7));
            tgt   = 16'($urandom_range(0, 65535));
            clr   = ($urandom_range(0, 31) == 0);
            #1;
            check_model("rand");
            model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
